// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB write master: FSM encoding and protocol constants.
package sccb_pkg;

  typedef enum logic [2:0] {IDLE, START, BITS, STOP, BUF} sccb_state_e;

  localparam int          SCCB_BITS    = 27;
  localparam int          QUARTERS     = 4;
  localparam logic [7:0]  OV7670_WR_ID = 8'h42;

  // The 9th bit of each phase is the slave's don't-care/ACK slot.
  function automatic logic is_ack_slot(input logic [4:0] slot);
    return (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
  endfunction

endpackage

// File: rtl/sccb_write_master_if.sv
// Request/status handshake plus SCCB pad-side signals for the write master.
interface sccb_write_master_if;
  logic       start;
  logic [7:0] addr;
  logic [7:0] data;
  logic       busy;
  logic       done;
  logic       nack;
  logic       sioc;
  logic       siod_out;
  logic       siod_oe;
  logic       siod_in;

  modport master (
    input  start, addr, data, siod_in,
    output busy, done, nack, sioc, siod_out, siod_oe
  );

  modport slave (
    output start, addr, data, siod_in,
    input  busy, done, nack, sioc, siod_out, siod_oe
  );
endinterface

// File: rtl/sccb_quarter_tick.sv
// Quarter-SIOC-period strobe: qtick on the last of every QDIV clk cycles.
module sccb_quarter_tick #(
  parameter int QDIV = 62
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic qtick
);

  localparam int CW = (QDIV > 2) ? $clog2(QDIV) : 1;

  logic [CW-1:0] cnt;

  assign qtick = (cnt == CW'(QDIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear)  cnt <= '0;
    else if (qtick)       cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/sccb_write_master.sv
// Single 3-phase SCCB write (ID, sub-address, data) with START/STOP and tBUF,
// all pad outputs registered so SIOC cannot glitch.
module sccb_write_master
  import sccb_pkg::*;
#(
  parameter int         CLK_FREQ  = 25000000,
  parameter int         SCCB_FREQ = 100000,
  parameter logic [7:0] DEV_ID    = OV7670_WR_ID
) (
  input logic                 clk,
  input logic                 rst_n,
  sccb_write_master_if.master bus
);

  localparam int QDIV = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int QW   = $clog2(QUARTERS);

  if (QDIV < 2) begin : g_qdiv_chk
    $error("sccb_write_master: QDIV must be at least 2");
  end

  sccb_state_e   state;
  logic [QW-1:0] q;
  logic [4:0]    bit_cnt;
  logic [23:0]   shift;
  logic          qtick;
  logic          qtick_d;
  logic [4:0]    bit_nxt;

  assign bit_nxt = bit_cnt + 5'd1;

  sccb_quarter_tick #(.QDIV(QDIV)) u_qtick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == IDLE),
    .qtick (qtick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      q            <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      qtick_d      <= 1'b0;
      bus.sioc     <= 1'b1;
      bus.siod_out <= 1'b1;
      bus.siod_oe  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.nack     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      qtick_d  <= qtick;

      // ACK sample on the first clk of q2, mid SIOC-high of the 9th bit
      if (state == BITS && q == QW'(2) && qtick_d && is_ack_slot(bit_cnt) && bus.siod_in)
        bus.nack <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy     <= 1'b1;
            bus.nack     <= 1'b0;
            shift        <= {DEV_ID, bus.addr, bus.data};
            bit_cnt      <= '0;
            q            <= '0;
            state        <= START;
            bus.sioc     <= 1'b1;
            bus.siod_out <= 1'b1;
            bus.siod_oe  <= 1'b1;
          end
        end

        START: begin
          if (qtick) begin
            q <= q + 1'b1;
            case (q)
              QW'(0): bus.siod_out <= 1'b0;
              QW'(2): bus.sioc     <= 1'b0;
              QW'(3): begin
                state        <= BITS;
                bus.siod_oe  <= 1'b1;
                bus.siod_out <= shift[23];
              end
              default: ;
            endcase
          end
        end

        BITS: begin
          if (qtick) begin
            q <= q + 1'b1;
            case (q)
              QW'(1): bus.sioc <= 1'b1;
              QW'(3): begin
                bus.sioc <= 1'b0;
                if (!is_ack_slot(bit_cnt))
                  shift <= {shift[22:0], 1'b0};
                if (bit_cnt == 5'(SCCB_BITS - 1)) begin
                  state        <= STOP;
                  bus.siod_oe  <= 1'b1;
                  bus.siod_out <= 1'b0;
                end else begin
                  bit_cnt <= bit_nxt;
                  if (is_ack_slot(bit_nxt)) begin
                    bus.siod_oe  <= 1'b0;
                    bus.siod_out <= 1'b1;
                  end else begin
                    // ACK slots do not shift, so the next MSB sits one place higher
                    bus.siod_oe  <= 1'b1;
                    bus.siod_out <= is_ack_slot(bit_cnt) ? shift[23] : shift[22];
                  end
                end
              end
              default: ;
            endcase
          end
        end

        STOP: begin
          if (qtick) begin
            q <= q + 1'b1;
            case (q)
              QW'(0): bus.sioc     <= 1'b1;
              QW'(1): bus.siod_out <= 1'b1;
              QW'(3): begin
                state       <= BUF;
                bus.siod_oe <= 1'b0;
              end
              default: ;
            endcase
          end
        end

        BUF: begin
          if (qtick) begin
            q <= q + 1'b1;
            if (q == QW'(QUARTERS - 1)) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_write_master.sv
// Directed bench: slave/decoder model with byte scoreboard and SIOD/SIOC protocol checker.
module tb_sccb_write_master;

  localparam int QD  = 62;
  localparam int LAT = 120 * QD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sccb_write_master_if bus();

  sccb_write_master #(
    .CLK_FREQ  (25000000),
    .SCCB_FREQ (100000),
    .DEV_ID    (8'h42)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic slave_pull = 1'b0;
  logic line;
  assign line        = bus.siod_oe ? bus.siod_out : ~slave_pull;
  assign bus.siod_in = line;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model, byte decoder and protocol checker
  logic [7:0] sb[$];
  logic [7:0] sh = '0;
  logic [7:0] exp_b;
  logic       p_sioc = 1'b1, p_line = 1'b1, idle_f = 1'b1;
  int bits = 0, byte_idx = 0, nak_byte = -1;
  int n_start = 0, n_stop = 0, nbytes = 0, proto_err = 0, last_tg = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      slave_pull = 1'b0;
      idle_f     = 1'b1;
      bits       = 0;
    end else begin
      if (!bus.busy) idle_f = 1'b1;
      else if (idle_f) begin idle_f = 1'b0; last_tg = cyc; end

      if (bus.busy && bus.sioc != p_sioc) begin
        if ((cyc - last_tg) % QD != 0) proto_err++;
        last_tg = cyc;
      end

      if (line != p_line && bus.sioc) begin
        if (!p_sioc) proto_err++;
        else if (!line) begin n_start++; bits = 0; byte_idx = 0; end
        else n_stop++;
      end

      if (!p_sioc && bus.sioc) begin
        if (bits < 8) begin
          sh = {sh[6:0], line};
          bits++;
          if (bits == 8) begin
            nbytes++;
            exp_b = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            checks++;
            assert (sh === exp_b) else begin
              failures++;
              $error("FAIL byte%0d observed=%02h expected=%02h", byte_idx, sh, exp_b);
            end
          end
        end else begin
          bits = 0;
          byte_idx++;
        end
      end

      if (p_sioc && !bus.sioc)
        slave_pull = (bits == 8) && (byte_idx != nak_byte);
    end
    p_sioc = bus.sioc;
    p_line = line;
  end

  int k = 0;

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge following the accepting edge (k=0).
  task automatic issue(input logic [7:0] a, input logic [7:0] d);
    bus.start = 1'b1;
    bus.addr  = a;
    bus.data  = d;
    sb.push_back(8'h42);
    sb.push_back(a);
    sb.push_back(d);
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
  endtask

  task automatic wait_k(input int t);
    while (k < t) tick();
  endtask

  task automatic wait_done(output int lat);
    while (!bus.done && k < LAT + 500) tick();
    lat = k;
  endtask

  task automatic clr_counts();
    n_start   = 0;
    n_stop    = 0;
    nbytes    = 0;
    proto_err = 0;
  endtask

  int lat, viol;

  initial begin
    bus.start = 1'b0;
    bus.addr  = '0;
    bus.data  = '0;
    repeat (4) @(negedge clk);
    chk("reset_outputs",
        {bus.sioc, bus.siod_out, bus.siod_oe, bus.busy, bus.done, bus.nack}, 6'b110000);
    rst_n = 1'b1;

    // Quiet idle bus
    viol = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!bus.sioc || bus.siod_oe || bus.busy || bus.done || bus.nack) viol++;
    end
    chk("idle_quiet", viol, 0);

    // Plain ACKed write
    clr_counts();
    nak_byte = -1;
    issue(8'h12, 8'h80);
    chk("busy_after_accept", bus.busy, 1);
    wait_done(lat);
    chk("latency_a", lat, LAT);
    chk("nack_a", bus.nack, 0);
    tick();
    chk("done_one_cycle", {bus.done, bus.busy}, 2'b00);
    chk("bytes_a", nbytes, 3);
    chk("starts_a", n_start, 1);
    chk("stops_a", n_stop, 1);
    chk("proto_a", proto_err, 0);

    // Second phase not ACKed; nack sticky; next start in the done cycle clears it
    clr_counts();
    nak_byte = 1;
    issue(8'h12, 8'h80);
    wait_k(74 * QD - 1);
    chk("nack_before_sample", bus.nack, 0);
    wait_k(74 * QD + 2);
    chk("nack_after_sample", bus.nack, 1);
    wait_done(lat);
    chk("latency_nak", lat, LAT);
    chk("nack_sticky_done", bus.nack, 1);
    chk("bytes_nak", nbytes, 3);
    clr_counts();
    nak_byte = -1;
    issue(8'h55, 8'hAA);
    chk("accept_in_done_cycle", bus.busy, 1);
    chk("nack_cleared", bus.nack, 0);
    wait_done(lat);
    chk("latency_chain", lat, LAT);
    chk("nack_chain", bus.nack, 0);
    chk("proto_chain", proto_err, 0);

    // Starts during a transfer are ignored
    tick();
    clr_counts();
    issue(8'h0C, 8'h33);
    wait_k(100);
    bus.start = 1'b1; bus.addr = 8'hFF; bus.data = 8'hFF;
    tick();
    bus.start = 1'b0;
    chk("busy_ign_100", bus.busy, 1);
    wait_k(5000);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_ign_5000", bus.busy, 1);
    wait_done(lat);
    chk("latency_ign", lat, LAT);
    chk("bytes_ign", nbytes, 3);
    chk("starts_ign", n_start, 1);
    chk("sb_empty_ign", sb.size(), 0);

    // Reset mid-transfer, then a normal write
    tick();
    issue(8'h77, 8'h66);
    wait_k(3000);
    rst_n = 1'b0;
    tick();
    chk("abort_outputs", {bus.sioc, bus.siod_oe, bus.busy, bus.done}, 4'b1000);
    rst_n = 1'b1;
    sb.delete();
    tick();
    clr_counts();
    issue(8'h3A, 8'h04);
    wait_done(lat);
    chk("latency_rst", lat, LAT);
    chk("bytes_rst", nbytes, 3);
    chk("nack_rst", bus.nack, 0);
    chk("starts_rst", n_start, 1);
    chk("stops_rst", n_stop, 1);
    chk("proto_rst", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sccb_write_master.md
Name: sccb_write_master

Overview:
- Downstream consumer of the manual-configuration keypad stage. It takes the latched register address, register data and one-cycle start pulse from that stage.
- Performs one SCCB 3-phase write transaction to the OV7670 camera: device ID, sub-address, data.
- Generates SIOC and drives/releases SIOD through an enable; the top level builds the tristate pad.
- Reports busy, done and a sticky NACK flag back to the configuration logic.

Parameters:
- CLK_FREQ, 25000000, system clock frequency in Hz.
- SCCB_FREQ, 100000, SIOC frequency in Hz.
- DEV_ID, 8'h42, SCCB write ID of the camera (7-bit 0x21 plus W bit).
- Derived constant QDIV = CLK_FREQ/(4*SCCB_FREQ), integer-truncated, equal to 62 at the defaults. It is the number of clk cycles per quarter SIOC period. QDIV must be at least 2, checked by elaboration assertion.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- addr  in  8  register sub-address, captured on accepted start.
- data  in  8  register data, captured on accepted start.
- busy  out  1  high from the accepting edge until done.
- done  out  1  one-cycle pulse at end of transaction, including bus-free time.
- nack  out  1  sticky; set if any of the three 9th bits read 1; cleared on next accepted start.
- sioc  out  1  SCCB clock.
- siod_out  out  1  SIOD value when driven.
- siod_oe  out  1  1 = drive SIOD, 0 = release (pull-up).
- siod_in  in  1  SIOD pad readback.

Behaviour:
- Reset is synchronous on rst_n, clk domain. Reset values: sioc=1, siod_out=1, siod_oe=0, busy=0, done=0, nack=0, state IDLE, quarter counter 0, bit counter 0, shift register 0.
- Reset mid-transaction aborts immediately to the reset values. No STOP is generated; the slave recovers on the next START.
- Quarter tick: a counter counts 0..QDIV-1 and emits qtick when it reaches QDIV-1. The counter is held at 0 in IDLE and restarts at 0 on start accept.
- Each state is 4 quarters (q0..q3), indexed by a 2-bit quarter counter that advances on qtick.
- Start accept: in IDLE with start=1, on that edge:
  - busy goes to 1 and nack goes to 0.
  - The shift register loads {DEV_ID, addr, data}.
  - The bit counter loads 0.
  - The state moves to START.
- start while busy=1 is ignored; there is no queueing.
- START: q0 sioc=1 siod=1; q1 and q2 sioc=1 siod=0; q3 sioc=0 siod=0. siod_oe=1 throughout.
- BITS: 27 bit slots (3 phases × (8 data bits MSB-first + 1 don't-care bit)).
  - SIOC per slot: q0 and q1 sioc=0; q2 and q3 sioc=1.
  - SIOD changes only at q0, while sioc=0.
  - Data bits: siod_oe=1 and siod_out = shift MSB. The shift register shifts left at the end of q3.
  - 9th bit (slots 8, 17, 26): siod_oe=0. siod_in is sampled on the first clk of q2; if it reads 1, nack is set.
- STOP: q0 sioc=0 siod=0 (oe=1); q1 sioc=1 siod=0; q2 and q3 sioc=1 siod=1.
- BUF: 4 quarters with sioc=1 and siod_oe=0. This is the tBUF bus-free time.
- At the end of BUF q3, return to IDLE. In the same edge busy goes to 0 and done goes to 1 for exactly one cycle.
- Latency: done=1 in the cycle that begins 120*QDIV clk edges after the accepting edge (4+108+4+4 quarters). At the defaults this is 7440 cycles. A start arriving in the done cycle is accepted.
- SIOC must never glitch. sioc, siod_out and siod_oe are all registered outputs.

Decomposition:
- Shared package sccb_pkg:
  - State encoding IDLE, START, BITS, STOP, BUF.
  - SCCB_BITS=27.
  - QUARTERS=4.
  - OV7670_WR_ID=8'h42.
- One sub-module, sccb_quarter_tick: parameter QDIV; ports clk, rst_n, clear, qtick.
- The FSM, shift register and SIOD/SIOC encoding stay in sccb_write_master.

Test Plan:
- Reset release, no start for 1000 cycles -> sioc=1, siod_oe=0, busy=0, done=0, nack=0 constantly.
- start with addr=8'h12, data=8'h80, slave model ACKs -> decoded bytes are 42,12,80. done pulses exactly 7440 cycles after accept. nack=0. One START and one STOP condition are observed.
- Same transfer but the slave leaves the 2nd 9th bit high -> nack=1 after the sample, still 1 after done, cleared on the next accepted start.
- start pulsed again at cycles 100 and 5000 of a transfer -> ignored: exactly one transaction, busy stays 1, no restart.
- rst_n low at cycle 3000 of a transfer -> next cycle sioc=1, siod_oe=0, busy=0, done=0. A following start with addr=8'h3A, data=8'h04 completes normally.
- SIOD protocol checker on all tests -> SIOD changes while sioc=1 only at START and STOP. Quarter spacing is QDIV=62 cycles.
